// File: rtl/aes_pkg.sv
// Shared AES byte-level definitions: state geometry, bank bookkeeping
// and the (Inv)ShiftRows index maps for column-major byte order.
package aes_pkg;

    localparam int NB          = 4;
    localparam int STATE_BYTES = 16;

    localparam logic [3:0] LAST_IDX = 4'(STATE_BYTES - 1);

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        BANK_EMPTY,
        BANK_FILLING,
        BANK_FULL
    } bank_state_t;

    // ShiftRows: output byte at (r, c) comes from (r, (c + r) mod 4).
    // Byte index k = 4c + r, so row is k[1:0] and column is k[3:2];
    // a 2-bit column sum wraps modulo NB for free.
    function automatic logic [3:0] shift_src(input logic [3:0] idx);
        logic [1:0] row;
        logic [1:0] col;
        row = idx[1:0];
        col = idx[3:2] + row;
        return {col, row};
    endfunction

    // InvShiftRows: output byte at (r, c) comes from (r, (c - r) mod 4).
    function automatic logic [3:0] inv_shift_src(input logic [3:0] idx);
        logic [1:0] row;
        logic [1:0] col;
        row = idx[1:0];
        col = idx[3:2] - row;
        return {col, row};
    endfunction

endpackage

// File: rtl/sr_bank.sv
// One 16-entry state bank: a single write port and an asynchronous
// read port, so the drain side sees the permuted byte in the same cycle.
module sr_bank
    import aes_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_we,
    input  logic [3:0]   i_waddr,
    input  logic [W-1:0] i_wdata,
    input  logic [3:0]   i_raddr,
    output logic [W-1:0] o_rdata
);

    logic [W-1:0] r_mem [STATE_BYTES];

    // Capture the accepted input byte at the write pointer.
    // NOTE: the storage array has no reset; a bank is only read once it is FULL,
    // and the top gates o_byte to zero whenever nothing valid is presented.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/inv_shift_rows_stream.sv
// Byte-serial (Inv)ShiftRows with a two-bank ping-pong buffer: one bank
// fills from the input stream while the other drains in permuted order.
module inv_shift_rows_stream
    import aes_pkg::*;
#(
    parameter int BYTE_W  = 8,
    parameter bit INVERSE = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [BYTE_W-1:0] i_byte,
    input  logic              i_last,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [BYTE_W-1:0] o_byte,
    output logic              o_last,
    output logic              o_err
);

    bank_state_t r_state [2];
    logic        r_wsel;
    logic        r_rsel;
    logic [3:0]  r_wptr;
    logic [3:0]  r_ridx;
    logic        r_err;

    logic              w_accept;
    logic              w_drain;
    logic [3:0]        w_src;
    logic [BYTE_W-1:0] w_rdata [2];

    // The write side stalls only while its target bank still awaits draining;
    // the read side presents data only from a completely filled bank.
    assign o_ready  = (r_state[r_wsel] != BANK_FULL);
    assign o_valid  = (r_state[r_rsel] == BANK_FULL);
    assign w_accept = i_valid && o_ready;
    assign w_drain  = o_valid && i_ready;

    assign w_src  = INVERSE ? inv_shift_src(r_ridx) : shift_src(r_ridx);
    assign o_byte = o_valid ? w_rdata[r_rsel] : '0;
    assign o_last = o_valid && (r_ridx == LAST_IDX);
    assign o_err  = r_err;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        sr_bank #(.W(BYTE_W)) u_bank (
            .i_clk   (i_clk),
            .i_we    (w_accept && (int'(r_wsel) == b)),
            .i_waddr (r_wptr),
            .i_wdata (i_byte),
            .i_raddr (w_src),
            .o_rdata (w_rdata[b])
        );
    end

    // Bank bookkeeping: drain and fill update independent banks each cycle.
    // Draining needs rsel's bank FULL and filling needs wsel's bank not FULL,
    // so the two r_state updates below can never target the same bank.
    // NOTE: all state here uses non-blocking assignments so every update sees
    // the pre-edge values, regardless of statement order inside the block.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state[0] <= BANK_EMPTY;
            r_state[1] <= BANK_EMPTY;
            r_wsel     <= 1'b0;
            r_rsel     <= 1'b0;
            r_wptr     <= '0;
            r_ridx     <= '0;
            r_err      <= 1'b0;
        end else begin
            r_err <= 1'b0;

            if (w_drain) begin
                if (r_ridx == LAST_IDX) begin
                    r_state[r_rsel] <= BANK_EMPTY;
                    r_rsel          <= ~r_rsel;
                    r_ridx          <= '0;
                end else begin
                    r_ridx <= r_ridx + 4'd1;
                end
            end

            if (w_accept) begin
                if (r_wptr == LAST_IDX) begin
                    // Byte 15 always commits; a missing i_last is still flagged.
                    r_state[r_wsel] <= BANK_FULL;
                    r_wsel          <= ~r_wsel;
                    r_wptr          <= '0;
                    r_err           <= ~i_last;
                end else if (i_last) begin
                    // Short block: drop it and restart the same bank.
                    r_state[r_wsel] <= BANK_EMPTY;
                    r_wptr          <= '0;
                    r_err           <= 1'b1;
                end else begin
                    r_state[r_wsel] <= BANK_FILLING;
                    r_wptr          <= r_wptr + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_inv_shift_rows_stream.sv
// Bench for inv_shift_rows_stream: an inverse and a forward instance share
// one input stream; a block-level model predicts both output streams.
module tb_inv_shift_rows_stream;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       i_valid = 1'b0;
    logic       i_last  = 1'b0;
    logic       i_ready = 1'b0;
    logic [7:0] i_byte  = 8'h00;

    logic       o_ready, o_valid, o_last, o_err;
    logic [7:0] o_byte;
    logic       f_ready, f_valid, f_last, f_err;
    logic [7:0] f_byte;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    inv_shift_rows_stream #(.BYTE_W(8), .INVERSE(1'b1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_byte(i_byte), .i_last(i_last), .o_valid(o_valid), .i_ready(i_ready),
        .o_byte(o_byte), .o_last(o_last), .o_err(o_err)
    );

    inv_shift_rows_stream #(.BYTE_W(8), .INVERSE(1'b0)) dut_fwd (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(f_ready),
        .i_byte(i_byte), .i_last(i_last), .o_valid(f_valid), .i_ready(i_ready),
        .o_byte(f_byte), .o_last(f_last), .o_err(f_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] part [16];
    int         part_n = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_fq[$];
    logic       exp_err = 1'b0;
    logic       m_rdy;

    logic [7:0] cap_q[$];
    logic [7:0] fcap_q[$];
    int dut_acc   = 0;
    int err_cnt   = 0;
    int valid_cyc = 0;
    int valid_run = 0;
    logic prev_v  = 1'b0;

    // A completed block viewed as a 4x4 matrix: row r is rotated right by r
    // for the inverse transform and left by r for the forward one.
    function automatic void commit_block();
        logic [7:0] m [4][4];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                m[r][c] = part[4*c + r];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                exp_q.push_back(m[r][(c + 4 - r) % 4]);
                exp_fq.push_back(m[r][(c + r) % 4]);
            end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            exp_fq.delete();
            part_n  = 0;
            exp_err = 1'b0;
            prev_v  = 1'b0;
        end else begin
            // At most two committed blocks can be held at once.
            m_rdy = ((exp_q.size() + 15) / 16) < 2;
            if (o_valid) valid_cyc++;
            if (o_valid && !prev_v) valid_run++;
            prev_v = o_valid;
            if (i_valid && o_ready) dut_acc++;
            if (o_valid && i_ready) cap_q.push_back(o_byte);
            if (f_valid && i_ready) fcap_q.push_back(f_byte);
            if (o_err) err_cnt++;

            exp_err = 1'b0;
            if (exp_q.size() > 0 && i_ready) begin
                void'(exp_q.pop_front());
                void'(exp_fq.pop_front());
            end
            if (i_valid && m_rdy) begin
                part[part_n] = i_byte;
                if (part_n == 15) begin
                    commit_block();
                    exp_err = !i_last;
                    part_n  = 0;
                end else if (i_last) begin
                    exp_err = 1'b1;
                    part_n  = 0;
                end else begin
                    part_n++;
                end
            end
        end
    end

    logic chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            check("o_valid", 32'(o_valid), 32'(exp_q.size() > 0));
            check("o_ready", 32'(o_ready), 32'(((exp_q.size() + 15) / 16) < 2));
            check("o_err",   32'(o_err),   32'(exp_err));
            check("f_valid", 32'(f_valid), 32'(exp_fq.size() > 0));
            check("f_err",   32'(f_err),   32'(exp_err));
            if (exp_q.size() > 0) begin
                check("o_byte", 32'(o_byte), 32'(exp_q[0]));
                check("o_last", 32'(o_last), 32'((exp_q.size() % 16) == 1));
                check("f_byte", 32'(f_byte), 32'(exp_fq[0]));
                check("f_last", 32'(f_last), 32'((exp_fq.size() % 16) == 1));
            end else begin
                check("o_last_idle", 32'(o_last), 32'd0);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push_byte(input logic [7:0] b, input logic l);
        int   n;
        logic acc;
        n   = 0;
        acc = 1'b0;
        @(negedge clk);
        i_valid = 1'b1;
        i_byte  = b;
        i_last  = l;
        while (!acc && n < 200) begin
            #4 acc = o_ready;
            @(posedge clk);
            n++;
            if (!acc) @(negedge clk);
        end
        #1;
        i_valid = 1'b0;
        i_last  = 1'b0;
        check("push_acc", 32'(acc), 32'd1);
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while ((exp_q.size() != 0 || o_valid) && w < 300) begin
            @(negedge clk);
            w++;
        end
        check("drain_q", 32'(exp_q.size()), 32'd0);
        check("drain_valid", 32'(o_valid), 32'd0);
    endtask

    logic [7:0] k_inv [16] = '{8'h00, 8'h0D, 8'h0A, 8'h07, 8'h04, 8'h01, 8'h0E, 8'h0B,
                               8'h08, 8'h05, 8'h02, 8'h0F, 8'h0C, 8'h09, 8'h06, 8'h03};
    logic [7:0] k_fwd [16] = '{8'h00, 8'h05, 8'h0A, 8'h0F, 8'h04, 8'h09, 8'h0E, 8'h03,
                               8'h08, 8'h0D, 8'h02, 8'h07, 8'h0C, 8'h01, 8'h06, 8'h0B};
    logic [7:0] k_frm [16] = '{8'h10, 8'h1D, 8'h1A, 8'h17, 8'h14, 8'h11, 8'h1E, 8'h1B,
                               8'h18, 8'h15, 8'h12, 8'h1F, 8'h1C, 8'h19, 8'h16, 8'h13};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int c0, f0, a0, e0, v0, r0, idx, w, kind, cut;
    logic rnd_done = 1'b0;

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        #1;
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_byte",  32'(o_byte),  32'd0);
        check("rst_last",  32'(o_last),  32'd0);
        check("rst_err",   32'(o_err),   32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        chk_en  = 1'b1;
        i_ready = 1'b1;

        // Directed block 00..0F through both instances
        c0 = cap_q.size();
        f0 = fcap_q.size();
        for (int i = 0; i < 16; i++) push_byte(8'(i), i == 15);
        wait_drain();
        check("dir_cnt", 32'(cap_q.size() - c0), 32'd16);
        for (int i = 0; i < 16; i++) begin
            check("dir_inv", 32'(cap_q[c0 + i]), 32'(k_inv[i]));
            check("dir_fwd", 32'(fcap_q[f0 + i]), 32'(k_fwd[i]));
        end

        // Three back-to-back blocks: 48 valid cycles in one unbroken run
        v0 = valid_cyc;
        r0 = valid_run;
        for (int i = 0; i < 48; i++) push_byte(8'($urandom), (i % 16) == 15);
        wait_drain();
        check("b2b_valid", 32'(valid_cyc - v0), 32'd48);
        check("b2b_runs",  32'(valid_run - r0), 32'd1);

        // Backpressure: 40 bytes offered with i_ready low
        i_ready = 1'b0;
        a0  = dut_acc;
        c0  = cap_q.size();
        idx = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            i_valid = 1'b1;
            i_byte  = 8'(idx);
            i_last  = (idx % 16) == 15;
            #4;
            if (o_ready) idx++;
        end
        @(negedge clk);
        i_valid = 1'b0;
        i_last  = 1'b0;
        #1;
        check("bp_acc",   32'(dut_acc - a0), 32'd32);
        check("bp_ready", 32'(o_ready), 32'd0);
        check("bp_byte",  32'(o_byte), 32'h00);
        repeat (4) @(negedge clk);
        #1 check("bp_hold", 32'(o_byte), 32'h00);
        i_ready = 1'b1;
        wait_drain();
        check("bp_cnt", 32'(cap_q.size() - c0), 32'd32);
        check("bp_b1",  32'(cap_q[c0 + 1]), 32'h0D);
        check("bp_b16", 32'(cap_q[c0 + 16]), 32'h10);

        // Framing: early i_last on the 6th byte, then a clean block
        e0 = err_cnt;
        c0 = cap_q.size();
        for (int i = 0; i < 6; i++) push_byte(8'(8'hA0 + i), i == 5);
        repeat (4) @(negedge clk);
        check("frm_err",   32'(err_cnt - e0), 32'd1);
        check("frm_noout", 32'(cap_q.size() - c0), 32'd0);
        for (int i = 0; i < 16; i++) push_byte(8'(8'h10 + i), i == 15);
        wait_drain();
        for (int i = 0; i < 16; i++) check("frm_blk", 32'(cap_q[c0 + i]), 32'(k_frm[i]));

        // Framing: byte 15 without i_last still commits and flags
        e0 = err_cnt;
        c0 = cap_q.size();
        for (int i = 0; i < 16; i++) push_byte(8'($urandom), 1'b0);
        wait_drain();
        check("nolast_err", 32'(err_cnt - e0), 32'd1);
        check("nolast_cnt", 32'(cap_q.size() - c0), 32'd16);

        // Random traffic with random backpressure and framing faults
        fork
            begin
                for (int b = 0; b < 24; b++) begin
                    kind = $urandom_range(0, 7);
                    cut  = $urandom_range(0, 14);
                    for (int i = 0; i < 16; i++) begin
                        if (kind == 0 && i > cut) break;
                        if ($urandom_range(0, 3) == 0) @(negedge clk);
                        push_byte(8'($urandom),
                                  (kind == 0) ? (i == cut) : ((kind == 1) ? 1'b0 : (i == 15)));
                    end
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(negedge clk);
                    i_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        i_ready = 1'b1;
        wait_drain();

        // Asynchronous reset in the middle of a drain (ridx = 7)
        c0 = cap_q.size();
        for (int i = 0; i < 16; i++) push_byte(8'($urandom), i == 15);
        w = 0;
        while ((cap_q.size() - c0) < 7 && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("mid_ridx", 32'(cap_q.size() - c0), 32'd7);
        #2 rst_n = 1'b0;
        #1;
        check("mid_valid", 32'(o_valid), 32'd0);
        check("mid_ready", 32'(o_ready), 32'd1);
        check("mid_byte",  32'(o_byte),  32'd0);
        check("mid_last",  32'(o_last),  32'd0);
        check("mid_fval",  32'(f_valid), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        c0 = cap_q.size();
        for (int i = 0; i < 16; i++) push_byte(8'($urandom), i == 15);
        wait_drain();
        check("post_rst_cnt", 32'(cap_q.size() - c0), 32'd16);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
